uart_rx_param: RTL and testbench

- Parametrised successor to the team's fixed 8-bit UART receiver. Supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits.
- Adds a two-flop input synchroniser, start-bit glitch rejection, framing and overrun detection, and a valid/ack output holding register.
- Sits between the external serial pin and the core's receive path, on the receive clock domain.

---
 rtl/uart_rx_param.sv | 109 ++++++++++
 tb/tb_uart_rx_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with synchroniser, glitch rejection, parity/framing/overrun flags and a valid/ack holding register
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int CPB_0     = 41667,
  parameter int CPB_1     = 20833,
  parameter int CPB_2     = 10417,
  parameter int CPB_3     = 5208
) (
  input  logic                 clkRx,
  input  logic                 reset,
  input  logic                 serialInput,
  input  logic [1:0]           baudRate,
  input  logic [1:0]           parity,
  input  logic                 stopBits,
  input  logic                 readAck,
  output logic [DATA_BITS-1:0] data,
  output logic                 dataValid,
  output logic                 parityError,
  output logic                 framingError,
  output logic                 overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                 r_state, w_next;
  logic                   r_sync, r_rx_s, r_rx_prev;
  logic [15:0]            r_cnt, r_cpb;
  logic [3:0]             r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [1:0]             r_par;
  logic                   r_two, r_stop_idx, r_par_err, r_frame_err;
  logic [15:0]            w_sel_cpb, w_half;
  logic                   w_start, w_tick, w_par_on, w_done, w_frame_fe;
  assign w_sel_cpb  = baudRate == 2'd0 ? 16'(CPB_0) : baudRate == 2'd1 ? 16'(CPB_1) :
                      baudRate == 2'd2 ? 16'(CPB_2) : 16'(CPB_3);
  assign w_half     = (r_cpb - 16'd1) >> 1;
  assign w_start    = r_rx_prev & ~r_rx_s;
  assign w_tick     = r_state == START ? r_cnt == w_half : r_cnt == r_cpb - 16'd1;
  assign w_par_on   = r_par == 2'b01 || r_par == 2'b10;
  assign w_done     = r_state == STOP && w_tick && (!r_two || r_stop_idx);
  assign w_frame_fe = r_frame_err | ~r_rx_s;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? START : IDLE;
      START:   if (w_tick) w_next = r_rx_s ? IDLE : DATA;
      DATA:    if (w_tick && r_idx == 4'(DATA_BITS - 1)) w_next = w_par_on ? PARITY : STOP;
      PARITY:  if (w_tick) w_next = STOP;
      STOP:    if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clkRx) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sync       <= 1'b1;
      r_rx_s       <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_cnt        <= '0;
      r_cpb        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_par        <= '0;
      r_two        <= 1'b0;
      r_stop_idx   <= 1'b0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      data         <= '0;
      dataValid    <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      r_sync    <= serialInput;
      r_rx_s    <= r_sync;
      r_rx_prev <= r_rx_s;
      r_state   <= w_next;
      r_cnt     <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 16'd1;
      // frame settings are frozen at the falling edge so mid-frame changes are ignored
      if (r_state == IDLE && w_start) begin
        r_cpb       <= w_sel_cpb;
        r_par       <= parity;
        r_two       <= stopBits;
        r_idx       <= '0;
        r_stop_idx  <= 1'b0;
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (r_state == DATA && w_tick) begin
        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
        r_idx   <= r_idx + 4'd1;
      end
      if (r_state == PARITY && w_tick) r_par_err <= (^r_shift) ^ r_rx_s ^ (r_par == 2'b01);
      if (r_state == STOP && w_tick) begin
        r_frame_err <= w_frame_fe;
        r_stop_idx  <= 1'b1;
      end
      // overrun can only be live while a word is held, so it tracks valid-and-not-acked
      if (w_done) begin
        data         <= r_shift;
        parityError  <= r_par_err;
        framingError <= w_frame_fe;
        dataValid    <= 1'b1;
        overrun      <= dataValid & ~readAck;
      end else if (readAck && dataValid) begin
        dataValid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against a frame-level model of the receiver's holding register
module tb_uart_rx_param;
  localparam int CPB = 16;
  typedef struct {int cyc; logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clk = 0, rst = 1, line = 1, sel5 = 0, ack = 0, ack5 = 0, sb = 0;
  logic [1:0] baud = 2'd3, par = 2'd0;
  logic ser_main, ser5;
  logic [7:0] data;
  logic [4:0] data5;
  logic dv, pe, fe, ov, dv5, pe5, fe5, ov5;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  logic m_v = 0, m_pe = 0, m_fe = 0, m_ov = 0, p_ack = 0, p_rst = 0, chk_on = 0;
  logic [7:0] m_d = 0;
  assign ser_main = sel5 ? 1'b1 : line;
  assign ser5     = sel5 ? line : 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_rx_param #(.DATA_BITS(8), .CPB_3(CPB)) dut (
    .clkRx(clk), .reset(rst), .serialInput(ser_main), .baudRate(baud), .parity(par),
    .stopBits(sb), .readAck(ack), .data(data), .dataValid(dv), .parityError(pe),
    .framingError(fe), .overrun(ov));
  uart_rx_param #(.DATA_BITS(5), .CPB_3(CPB)) dut5 (
    .clkRx(clk), .reset(rst), .serialInput(ser5), .baudRate(baud), .parity(par),
    .stopBits(sb), .readAck(ack5), .data(data5), .dataValid(dv5), .parityError(pe5),
    .framingError(fe5), .overrun(ov5));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // model: a frame completes at its final stop sample; the holding register follows valid/ack rules
  always @(negedge clk) begin
    if (p_rst) begin
      m_v = 0; m_d = 0; m_pe = 0; m_fe = 0; m_ov = 0; chk_on = 1;
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      if (m_v && !p_ack) m_ov = 1;
      else if (m_v && p_ack) m_ov = 0;
      m_v = 1; m_d = q[0].d; m_pe = q[0].pe; m_fe = q[0].fe;
      void'(q.pop_front());
    end else if (p_ack && m_v) begin
      m_v = 0; m_ov = 0;
    end
    if (chk_on) begin
      check("data", data, m_d);
      check("dataValid", dv, m_v);
      check("parityError", pe, m_pe);
      check("framingError", fe, m_fe);
      check("overrun", ov, m_ov);
    end
    p_ack = ack;
    p_rst = rst;
  end
  task automatic send(input logic [8:0] d, input int db, input logic [1:0] pm, input logic pbit,
                      input logic s2, input logic st1, input logic st2, input bit push);
    logic [15:0] bits;
    int n, e;
    exp_t x;
    bits = '0;
    for (int i = 0; i < db; i++) bits[1+i] = d[i];
    n = 1 + db;
    if (pm == 2'b01 || pm == 2'b10) begin bits[n] = pbit; n++; end
    bits[n] = st1; n++;
    if (s2) begin bits[n] = st2; n++; end
    @(posedge clk); #1;
    par = pm; sb = s2; e = cyc;
    if (push) begin
      x.cyc = e + 4 + (CPB - 1) / 2 + CPB * (n - 1);
      x.d   = d[7:0];
      x.pe  = pm == 2'b01 ? ((^d[7:0]) ^ pbit) == 1'b0 : pm == 2'b10 ? ((^d[7:0]) ^ pbit) == 1'b1 : 1'b0;
      x.fe  = !st1 || (s2 && !st2);
      q.push_back(x);
    end
    for (int i = 0; i < n; i++) begin
      line = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    line = 1;
  endtask
  task automatic ack_pulse();
    @(posedge clk); #1 ack = 1;
    @(posedge clk); #1 ack = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int t0, lat, target;
    exp_t x;
    idle(3);
    rst = 0;
    idle(4);
    check("reset_dv", dv, 0);
    check("reset_data", data, 0);
    fork
      send(9'hA5, 8, 2'b00, 0, 0, 1, 1, 1);
      begin
        wait (line == 0);
        t0 = cyc;
        for (int i = 0; i < 400 && !dv; i++) @(negedge clk);
        lat = cyc - t0;
        check("latency_in_154pm1", (lat >= 153 && lat <= 155), 1);
      end
    join
    idle(2);
    check("t1_data", data, 8'hA5);
    check("t1_flags", {pe, fe, ov}, 3'b000);
    ack_pulse();
    send(9'hA5, 8, 2'b10, 0, 0, 1, 1, 1);
    idle(2);
    check("even_ok_pe", pe, 0);
    ack_pulse();
    send(9'hA5, 8, 2'b10, 1, 0, 1, 1, 1);
    idle(2);
    check("even_bad_pe", pe, 1);
    check("even_bad_dv", dv, 1);
    ack_pulse();
    send(9'h0F, 8, 2'b01, 1, 0, 1, 1, 1);
    idle(2);
    ack_pulse();
    line = 0;
    idle(5);
    line = 1;
    idle(60);
    check("glitch_dv", dv, 0);
    send(9'h3C, 8, 2'b00, 0, 0, 1, 1, 1);
    idle(2);
    check("after_glitch_data", data, 8'h3C);
    ack_pulse();
    send(9'h11, 8, 2'b00, 0, 0, 1, 1, 1);
    send(9'h22, 8, 2'b00, 0, 0, 1, 1, 1);
    idle(2);
    check("ovr_data", data, 8'h22);
    check("ovr_flag", ov, 1);
    ack_pulse();
    idle(1);
    check("ack_dv", dv, 0);
    check("ack_ovr", ov, 0);
    send(9'h11, 8, 2'b00, 0, 0, 1, 1, 1);
    fork
      send(9'h22, 8, 2'b00, 0, 0, 1, 1, 1);
      begin
        idle(2);
        target = q[$].cyc;
        while (cyc < target - 1) begin @(posedge clk); #1; end
        ack = 1;
        @(posedge clk); #1 ack = 0;
      end
    join
    idle(2);
    check("same_cycle_ack_ovr", ov, 0);
    check("same_cycle_ack_dv", dv, 1);
    check("same_cycle_ack_data", data, 8'h22);
    ack_pulse();
    send(9'h5A, 8, 2'b00, 0, 1, 1, 0, 1);
    idle(2);
    check("stop2_fe", fe, 1);
    check("stop2_data", data, 8'h5A);
    ack_pulse();
    @(posedge clk); #1;
    line = 0; sb = 1; par = 0;
    x.cyc = cyc + 4 + (CPB - 1) / 2 + CPB * 10; x.d = 8'h00; x.pe = 0; x.fe = 1;
    q.push_back(x);
    idle(200);
    line = 1;
    idle(60);
    check("break_data", data, 8'h00);
    check("break_fe", fe, 1);
    check("break_single_word", {dv, ov}, 2'b10);
    ack_pulse();
    sb = 0;
    @(posedge clk); #1 line = 0;
    idle(CPB + 3 * CPB + CPB / 2);
    rst = 1;
    idle(1);
    rst = 0;
    line = 1;
    idle(250);
    check("abort_dv", dv, 0);
    send(9'h81, 8, 2'b00, 0, 0, 1, 1, 1);
    idle(2);
    check("after_abort_data", data, 8'h81);
    ack_pulse();
    sel5 = 1;
    send(9'h15, 5, 2'b00, 0, 0, 1, 1, 0);
    idle(4);
    sel5 = 0;
    check("db5_data", data5, 5'h15);
    check("db5_valid", dv5, 1);
    check("db5_fe", fe5, 0);
    idle(4);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
